pwm_multi_duty_ctrl: RTL and testbench

//  Parametrised N-channel PWM generator with push-button duty control, all on slow_clk.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_btn_repeat.sv | 78 +++++++
 rtl/pwm_multi_duty_ctrl.sv | 100 ++++++++++
 tb/tb_pwm_multi_duty_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants, button-repeat state encoding and a width helper.
package pwm_pkg;

  localparam int unsigned N_CH_DEF       = 2;
  localparam int unsigned PWM_PERIOD_DEF = 100;
  localparam int unsigned STEP_DEF       = 10;
  localparam int unsigned INIT_DUTY_DEF  = 50;
  localparam int unsigned HOLD_CYC_DEF   = 20;
  localparam int unsigned REPEAT_CYC_DEF = 5;

  typedef enum logic [1:0] {
    BTN_IDLE = 2'd0,
    BTN_HOLD = 2'd1,
    BTN_RPT  = 2'd2
  } btn_state_t;

  // $clog2 that never returns less than 1, so it is always usable as a width.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_btn_repeat.sv
// Edge detect plus hold-to-repeat for one debounced button; emits 1-cycle event pulses.
module pwm_btn_repeat
  import pwm_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic slow_clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned CW      = clog2_safe(MAX_CYC + 1);

  btn_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          btn_q;
  logic          pulse_nxt;

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      state <= BTN_IDLE;
      cnt   <= '0;
      btn_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      btn_q <= btn;
      pulse <= pulse_nxt;
    end
  end

  // Rise fires at once; HOLD_CYC cycles later repeat starts, then every REPEAT_CYC.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    if (!btn) begin
      state_nxt = BTN_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        BTN_IDLE: begin
          if (!btn_q) begin
            pulse_nxt = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = (HOLD_CYC == 0) ? BTN_IDLE : BTN_HOLD;
          end
        end
        BTN_HOLD: begin
          if (cnt == CW'(HOLD_CYC)) begin
            pulse_nxt = 1'b1;
            cnt_nxt   = CW'(1);
            state_nxt = BTN_RPT;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        BTN_RPT: begin
          if (cnt == CW'(REPEAT_CYC)) begin
            pulse_nxt = 1'b1;
            cnt_nxt   = CW'(1);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = BTN_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_multi_duty_ctrl.sv
// N-channel PWM with button-driven duty of the selected channel, applied at period boundaries.
module pwm_multi_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH       = N_CH_DEF,
  parameter int unsigned PERIOD     = PWM_PERIOD_DEF,
  parameter int unsigned STEP       = STEP_DEF,
  parameter int unsigned INIT_DUTY  = INIT_DUTY_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic                                     slow_clk,
  input  logic                                     rst,
  input  logic                                     pb_inc,
  input  logic                                     pb_dec,
  input  logic                                     pb_sel,
  output logic [N_CH-1:0]                          pwm_out,
  output logic [N_CH*clog2_safe(PERIOD+1)-1:0]     duty_bus,
  output logic [clog2_safe(N_CH)-1:0]              sel_ch
);

  localparam int unsigned DW  = clog2_safe(PERIOD + 1);
  localparam int unsigned DW1 = DW + 1;
  localparam int unsigned SW  = clog2_safe(N_CH);

  logic          evt_inc, evt_dec, evt_sel;
  logic          step_en;
  logic [DW-1:0] cnt;
  logic          last_cnt;

  pwm_btn_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_inc (
    .slow_clk(slow_clk), .rst(rst), .btn(pb_inc), .pulse(evt_inc)
  );

  pwm_btn_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_dec (
    .slow_clk(slow_clk), .rst(rst), .btn(pb_dec), .pulse(evt_dec)
  );

  pwm_btn_repeat #(.HOLD_CYC(0), .REPEAT_CYC(1)) u_sel (
    .slow_clk(slow_clk), .rst(rst), .btn(pb_sel), .pulse(evt_sel)
  );

  // Simultaneous inc and dec cancel each other.
  assign step_en  = evt_inc ^ evt_dec;
  assign last_cnt = (cnt == DW'(PERIOD - 1));

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (last_cnt) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      sel_ch <= '0;
    end else if (evt_sel) begin
      sel_ch <= (sel_ch == SW'(N_CH - 1)) ? '0 : sel_ch + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DW-1:0]  shadow, active;
    logic           pwm_q;
    logic [DW1-1:0] wide, up_val, dn_val;

    // Saturating step, computed one bit wider so nothing can wrap.
    always_comb begin
      wide   = {1'b0, shadow};
      up_val = wide + DW1'(STEP);
      if (up_val > DW1'(PERIOD)) begin
        up_val = DW1'(PERIOD);
      end
      dn_val = (wide < DW1'(STEP)) ? '0 : wide - DW1'(STEP);
    end

    always_ff @(posedge slow_clk or negedge rst) begin
      if (!rst) begin
        shadow <= DW'(INIT_DUTY);
        active <= DW'(INIT_DUTY);
        pwm_q  <= 1'b0;
      end else begin
        if (step_en && (sel_ch == SW'(i))) begin
          shadow <= evt_inc ? up_val[DW-1:0] : dn_val[DW-1:0];
        end
        if (last_cnt) begin
          active <= shadow;
        end
        pwm_q <= (cnt < active);
      end
    end

    assign pwm_out[i]            = pwm_q;
    assign duty_bus[i*DW +: DW]  = active;
  end

endmodule

// File: tb/tb_pwm_multi_duty_ctrl.sv
// Directed plus randomized button stimulus against a behavioural PWM/duty model.
module tb_pwm_multi_duty_ctrl;

  localparam int NCH    = 2;
  localparam int PERIOD = 100;
  localparam int STEP   = 10;
  localparam int INIT   = 50;
  localparam int HOLD   = 20;
  localparam int REPEAT = 5;
  localparam int DW     = $clog2(PERIOD + 1);

  logic              slow_clk = 1'b0;
  logic              rst;
  logic              pb_inc, pb_dec, pb_sel;
  logic [NCH-1:0]    pwm_out;
  logic [NCH*DW-1:0] duty_bus;
  logic [0:0]        sel_ch;

  pwm_multi_duty_ctrl dut (
    .slow_clk(slow_clk), .rst(rst), .pb_inc(pb_inc), .pb_dec(pb_dec), .pb_sel(pb_sel),
    .pwm_out(pwm_out), .duty_bus(duty_bus), .sel_ch(sel_ch)
  );

  always #5 slow_clk = ~slow_clk;

  int checks = 0;
  int passes = 0;

  // Reference model state: value of each observable after the latest clock edge.
  int m_sh [NCH];
  int m_act[NCH];
  bit m_pwm[NCH];
  int m_sel, m_ph;
  int h_inc, h_dec, h_sel;
  bit e_inc, e_dec, e_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sh[c] = INIT; m_act[c] = INIT; m_pwm[c] = 1'b0;
    end
    m_sel = 0; m_ph = 0;
    h_inc = 0; h_dec = 0; h_sel = 0;
    e_inc = 0; e_dec = 0; e_sel = 0;
  endtask

  // h = number of consecutive high samples ending now.
  function automatic bit btn_event(input int h, input bit rep);
    if (h == 1) return 1'b1;
    if (rep && (h - 1 >= HOLD) && (((h - 1 - HOLD) % REPEAT) == 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input bit i, input bit d, input bit s);
    for (int c = 0; c < NCH; c++) m_pwm[c] = (m_ph < m_act[c]);
    if (m_ph == PERIOD - 1) for (int c = 0; c < NCH; c++) m_act[c] = m_sh[c];
    if (e_inc && !e_dec) m_sh[m_sel] = (m_sh[m_sel] + STEP > PERIOD) ? PERIOD : m_sh[m_sel] + STEP;
    if (e_dec && !e_inc) m_sh[m_sel] = (m_sh[m_sel] < STEP) ? 0 : m_sh[m_sel] - STEP;
    if (e_sel) m_sel = (m_sel + 1) % NCH;
    m_ph  = (m_ph + 1) % PERIOD;
    h_inc = i ? h_inc + 1 : 0;
    h_dec = d ? h_dec + 1 : 0;
    h_sel = s ? h_sel + 1 : 0;
    e_inc = i && btn_event(h_inc, 1'b1);
    e_dec = d && btn_event(h_dec, 1'b1);
    e_sel = s && btn_event(h_sel, 1'b0);
  endtask

  function automatic logic [31:0] exp_bus();
    logic [NCH*DW-1:0] b;
    for (int c = 0; c < NCH; c++) b[c*DW +: DW] = DW'(m_act[c]);
    return 32'(b);
  endfunction

  function automatic logic [31:0] exp_pwm();
    logic [NCH-1:0] p;
    for (int c = 0; c < NCH; c++) p[c] = m_pwm[c];
    return 32'(p);
  endfunction

  task automatic compare_all();
    check("pwm_out", 32'(pwm_out), exp_pwm());
    check("duty_bus", 32'(duty_bus), exp_bus());
    check("sel_ch", 32'(sel_ch), 32'(m_sel));
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic cyc(input bit i, input bit d, input bit s);
    pb_inc = i; pb_dec = d; pb_sel = s;
    @(posedge slow_clk);
    model_edge(i, d, s);
    @(negedge slow_clk);
    compare_all();
  endtask

  task automatic press(input bit i, input bit d, input bit s, input int len, input int gap);
    repeat (len) cyc(i, d, s);
    repeat (gap) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic count_highs(input int ch, output int highs);
    highs = 0;
    repeat (PERIOD) begin
      cyc(1'b0, 1'b0, 1'b0);
      highs += int'(pwm_out[ch]);
    end
  endtask

  function automatic int duty_of(input int ch);
    return int'(duty_bus[ch*DW +: DW]);
  endfunction

  int highs;
  logic [NCH*DW-1:0] init_bus;

  initial begin
    for (int c = 0; c < NCH; c++) init_bus[c*DW +: DW] = DW'(INIT);
    rst = 1'b0; pb_inc = 1'b0; pb_dec = 1'b0; pb_sel = 1'b0;
    model_reset();
    repeat (3) @(negedge slow_clk);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_duty", 32'(duty_bus), 32'(init_bus));
    check("reset_sel", 32'(sel_ch), 32'd0);
    rst = 1'b1;

    // Reset release: 50/100 on both channels.
    press(0, 0, 0, 0, 5);
    count_highs(0, highs); check("init_ch0_highs", 32'(highs), 32'd50);
    count_highs(1, highs); check("init_ch1_highs", 32'(highs), 32'd50);

    // Single inc pulse on ch0.
    press(1, 0, 0, 3, 2 * PERIOD);
    check("inc_ch0_duty", 32'(duty_of(0)), 32'd60);
    check("inc_ch1_duty", 32'(duty_of(1)), 32'd50);
    count_highs(0, highs); check("inc_ch0_highs", 32'(highs), 32'd60);

    // Inc held 40 cycles saturates at PERIOD; another press stays there.
    press(1, 0, 0, 40, 2 * PERIOD);
    check("hold_ch0_duty", 32'(duty_of(0)), 32'(PERIOD));
    press(1, 0, 0, 3, 2 * PERIOD);
    check("sat_ch0_duty", 32'(duty_of(0)), 32'(PERIOD));
    count_highs(0, highs); check("sat_ch0_highs", 32'(highs), 32'(PERIOD));

    // Down to 10, then two more decs clamp at 0.
    repeat (9) press(0, 1, 0, 3, 3);
    press(0, 0, 0, 0, 2 * PERIOD);
    check("dec_ch0_10", 32'(duty_of(0)), 32'd10);
    repeat (2) press(0, 1, 0, 3, 3);
    press(0, 0, 0, 0, 2 * PERIOD);
    check("dec_ch0_clamp", 32'(duty_of(0)), 32'd0);
    count_highs(0, highs); check("zero_ch0_highs", 32'(highs), 32'd0);

    // Simultaneous inc+dec, select wrap, select+inc together.
    press(1, 1, 0, 3, 2 * PERIOD);
    check("incdec_ch0", 32'(duty_of(0)), 32'd0);
    press(0, 0, 1, 3, 3);
    check("sel_to_1", 32'(sel_ch), 32'd1);
    press(0, 0, 1, 3, 3);
    check("sel_to_0", 32'(sel_ch), 32'd0);
    press(1, 0, 1, 3, 2 * PERIOD);
    check("selinc_ch0", 32'(duty_of(0)), 32'd10);
    check("selinc_ch1", 32'(duty_of(1)), 32'd50);
    check("selinc_sel", 32'(sel_ch), 32'd1);

    // Randomized button activity.
    repeat (25) begin
      int pat, len, gap;
      pat = int'($urandom_range(0, 7));
      len = int'($urandom_range(1, 45));
      gap = int'($urandom_range(1, 12));
      press(pat[0], pat[1], pat[2], len, gap);
    end
    press(0, 0, 0, 0, 2 * PERIOD);

    // Reset mid-period with a pending shadow change.
    press(0, 1, 0, 3, 2);
    press(1, 0, 0, 3, 2);
    #2 rst = 1'b0;
    #1;
    check("midrst_pwm", 32'(pwm_out), 32'd0);
    check("midrst_duty", 32'(duty_bus), 32'(init_bus));
    check("midrst_sel", 32'(sel_ch), 32'd0);
    @(negedge slow_clk);
    rst = 1'b1;
    model_reset();
    press(0, 0, 0, 0, 2 * PERIOD);
    check("post_rst_duty", 32'(duty_bus), 32'(init_bus));
    count_highs(1, highs); check("post_rst_ch1_highs", 32'(highs), 32'd50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
